udma_hyperbus_trans_arb: RTL and testbench



---
 rtl/udma_hyperbus_trans_arb.sv | 182 ++++++++++++++++++
 tb/tb_udma_hyperbus_trans_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_hyperbus_trans_arb.sv
// Round-robin scheduler that forwards per-channel HyperBus transactions, one at a time, to a single PHY port.
// Optional feature macro HYPER_BURST_SPLIT_EN: split linear memory bursts into chunks of at most MAX_BURST bytes.
module udma_hyperbus_trans_arb #(
    parameter int NB_CH      = 8,
    parameter int NR_CS      = 2,
    parameter int TRANS_SIZE = 16,
    parameter int MAX_BURST  = 1024,
    parameter int ID_W       = $clog2(NB_CH)
) (
    input  logic                                sys_clk_i,
    input  logic                                rst_ni,
    input  logic [NB_CH-1:0]                    ch_trans_valid_i,
    output logic [NB_CH-1:0]                    ch_trans_ready_o,
    input  logic [NB_CH-1:0][31:0]              ch_trans_addr_i,
    input  logic [NB_CH-1:0][NR_CS-1:0]         ch_trans_cs_i,
    input  logic [NB_CH-1:0]                    ch_trans_write_i,
    input  logic [NB_CH-1:0][TRANS_SIZE-1:0]    ch_trans_burst_i,
    input  logic [NB_CH-1:0]                    ch_trans_burst_type_i,
    input  logic [NB_CH-1:0]                    ch_trans_address_space_i,
    output logic                                trans_valid_o,
    input  logic                                trans_ready_i,
    output logic [31:0]                         trans_address_o,
    output logic [NR_CS-1:0]                    trans_cs_o,
    output logic                                trans_write_o,
    output logic [TRANS_SIZE-1:0]               trans_burst_o,
    output logic                                trans_burst_type_o,
    output logic                                trans_address_space_o,
    input  logic                                trans_done_i,
    output logic                                gnt_active_o,
    output logic [ID_W-1:0]                     gnt_id_o,
    output logic [NB_CH-1:0]                    evt_eot_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;

    if (NB_CH < 2 || MAX_BURST < 2 || (MAX_BURST % 2) != 0 ||
        longint'(MAX_BURST) >= (64'd1 << TRANS_SIZE)) begin : g_bad_params
        $error("udma_hyperbus_trans_arb: invalid NB_CH or MAX_BURST");
    end

    state_t                  state_reg, state_next;
    logic [ID_W-1:0]         rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]         gnt_id_reg, gnt_id_next;
    logic                    gnt_active_reg, gnt_active_next;
    logic [31:0]             addr_reg, addr_next;
    logic [TRANS_SIZE-1:0]   remaining_reg, remaining_next;
    logic [NR_CS-1:0]        cs_reg, cs_next;
    logic                    write_reg, write_next;
    logic                    btype_reg, btype_next;
    logic                    aspace_reg, aspace_next;
    logic [NB_CH-1:0]        eot_reg, eot_next;
    logic [NB_CH-1:0]        grant;
    logic [TRANS_SIZE-1:0]   chunk;
    logic                    last_chunk;

    // Candidate gi is the channel gi positions after rr_ptr; the lowest valid candidate wins.
    logic [NB_CH-1:0]            cand_valid;
    logic [NB_CH-1:0][ID_W-1:0]  cand_id;
    logic                        pick_found;
    logic [ID_W-1:0]             pick_id;

    for (genvar gi = 0; gi < NB_CH; gi++) begin : g_rot
        assign cand_id[gi]    = ID_W'((int'(rr_ptr_reg) + gi) % NB_CH);
        assign cand_valid[gi] = ch_trans_valid_i[cand_id[gi]];
    end

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                pick_found = 1'b1;
                pick_id    = cand_id[i];
            end
        end
    end

`ifdef HYPER_BURST_SPLIT_EN
    localparam logic [TRANS_SIZE-1:0] MAX_CHUNK = TRANS_SIZE'(MAX_BURST);
    assign chunk      = (btype_reg && !aspace_reg && remaining_reg > MAX_CHUNK) ? MAX_CHUNK : remaining_reg;
    assign last_chunk = (remaining_reg == chunk);
`else
    assign chunk      = remaining_reg;
    assign last_chunk = 1'b1;
`endif

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        gnt_id_next     = gnt_id_reg;
        gnt_active_next = gnt_active_reg;
        addr_next       = addr_reg;
        remaining_next  = remaining_reg;
        cs_next         = cs_reg;
        write_next      = write_reg;
        btype_next      = btype_reg;
        aspace_next     = aspace_reg;
        eot_next        = '0;
        grant           = '0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant[pick_id] = 1'b1;
                    rr_ptr_next    = (pick_id == ID_W'(NB_CH - 1)) ? '0 : pick_id + 1'b1;
                    gnt_id_next    = pick_id;
                    addr_next      = ch_trans_addr_i[pick_id];
                    remaining_next = ch_trans_burst_i[pick_id];
                    cs_next        = ch_trans_cs_i[pick_id];
                    write_next     = ch_trans_write_i[pick_id];
                    btype_next     = ch_trans_burst_type_i[pick_id];
                    aspace_next    = ch_trans_address_space_i[pick_id];
                    // An empty request completes immediately without touching the PHY.
                    if (ch_trans_burst_i[pick_id] == '0) begin
                        eot_next[pick_id] = 1'b1;
                    end else begin
                        state_next      = ISSUE;
                        gnt_active_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (trans_ready_i) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (trans_done_i) begin
                    remaining_next = remaining_reg - chunk;
                    addr_next      = addr_reg + 32'(chunk);
                    if (last_chunk) begin
                        state_next           = IDLE;
                        gnt_active_next      = 1'b0;
                        eot_next[gnt_id_reg] = 1'b1;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            gnt_id_reg     <= '0;
            gnt_active_reg <= 1'b0;
            addr_reg       <= '0;
            remaining_reg  <= '0;
            cs_reg         <= '0;
            write_reg      <= 1'b0;
            btype_reg      <= 1'b0;
            aspace_reg     <= 1'b0;
            eot_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            gnt_id_reg     <= gnt_id_next;
            gnt_active_reg <= gnt_active_next;
            addr_reg       <= addr_next;
            remaining_reg  <= remaining_next;
            cs_reg         <= cs_next;
            write_reg      <= write_next;
            btype_reg      <= btype_next;
            aspace_reg     <= aspace_next;
            eot_reg        <= eot_next;
        end
    end

    // Accept is combinational from the request, so mask it while reset holds the block idle.
    assign ch_trans_ready_o      = {NB_CH{rst_ni}} & grant;
    assign trans_valid_o         = (state_reg == ISSUE);
    assign trans_address_o       = addr_reg;
    assign trans_cs_o            = cs_reg;
    assign trans_write_o         = write_reg;
    assign trans_burst_o         = chunk;
    assign trans_burst_type_o    = btype_reg;
    assign trans_address_space_o = aspace_reg;
    assign gnt_active_o          = gnt_active_reg;
    assign gnt_id_o              = gnt_id_reg;
    assign evt_eot_o             = eot_reg;

endmodule

// File: tb/tb_udma_hyperbus_trans_arb.sv
// Bench for udma_hyperbus_trans_arb: transaction-level model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_udma_hyperbus_trans_arb;
    localparam int NB = 8, NCS = 2, TS = 16, MAXB = 1024, IDW = 3;
`ifdef HYPER_BURST_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [NB-1:0]          ch_valid, ch_ready, ch_wr, ch_btype, ch_asp;
    logic [NB-1:0][31:0]    ch_addr;
    logic [NB-1:0][NCS-1:0] ch_cs;
    logic [NB-1:0][TS-1:0]  ch_burst;
    logic                   trans_valid, trans_ready, trans_write, trans_btype, trans_asp, trans_done;
    logic [31:0]            trans_addr;
    logic [NCS-1:0]         trans_cs;
    logic [TS-1:0]          trans_burst;
    logic                   gnt_active;
    logic [IDW-1:0]         gnt_id;
    logic [NB-1:0]          evt_eot;

    udma_hyperbus_trans_arb #(.NB_CH(NB), .NR_CS(NCS), .TRANS_SIZE(TS), .MAX_BURST(MAXB), .ID_W(IDW)) dut (
        .sys_clk_i(clk), .rst_ni(rst_n),
        .ch_trans_valid_i(ch_valid), .ch_trans_ready_o(ch_ready), .ch_trans_addr_i(ch_addr),
        .ch_trans_cs_i(ch_cs), .ch_trans_write_i(ch_wr), .ch_trans_burst_i(ch_burst),
        .ch_trans_burst_type_i(ch_btype), .ch_trans_address_space_i(ch_asp),
        .trans_valid_o(trans_valid), .trans_ready_i(trans_ready), .trans_address_o(trans_addr),
        .trans_cs_o(trans_cs), .trans_write_o(trans_write), .trans_burst_o(trans_burst),
        .trans_burst_type_o(trans_btype), .trans_address_space_o(trans_asp), .trans_done_i(trans_done),
        .gnt_active_o(gnt_active), .gnt_id_o(gnt_id), .evt_eot_o(evt_eot)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- PHY responder ----------------
    int rdy_delay = 0, done_delay = 1;
    int stray_req = 0, stray_ack = 0;
    int phy_phase = 0, wcnt = 0, dcnt = 0;

    initial begin
        trans_ready = 1'b0;
        trans_done  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                trans_ready = 1'b0; trans_done = 1'b0; phy_phase = 0; wcnt = 0; dcnt = 0;
            end else if (phy_phase == 0) begin
                trans_done = 1'b0;
                if (trans_ready) begin
                    trans_ready = 1'b0; phy_phase = 1; dcnt = 0;
                end else if (stray_req != stray_ack) begin
                    trans_done = 1'b1; stray_ack = stray_req;
                end else if (trans_valid) begin
                    if (wcnt >= rdy_delay) begin trans_ready = 1'b1; wcnt = 0; end
                    else wcnt++;
                end
            end else begin
                if (trans_done) begin trans_done = 1'b0; phy_phase = 0; end
                else if (dcnt >= done_delay) trans_done = 1'b1;
                else dcnt++;
            end
        end
    end

    // ---------------- Behavioural model and compare ----------------
    bit              m_busy = 0, m_issue = 0;
    int              m_owner = 0, m_rr = 0;
    logic [IDW-1:0]  m_gnt = '0;
    logic [NB-1:0]   m_eot = '0, m_eot_n;
    logic [NCS-1:0]  m_cs;
    bit              m_wr, m_bt, m_as;
    logic [31:0]     q_addr[$];
    int              q_len[$];
    int              g_log[$];
    logic [31:0]     c_addr[$];
    int              c_len[$];
    int              valid_cycles = 0;

    always @(negedge clk) begin
        logic [NB-1:0] exp_ready;
        int pick, rem, len;
        bit logged;
        logic [31:0] a;
        if (!rst_n) begin
            chk("rst_ready", ch_ready, 0);
            chk("rst_trans_valid", trans_valid, 0);
            chk("rst_trans_addr", trans_addr, 0);
            chk("rst_trans_burst", trans_burst, 0);
            chk("rst_trans_attr", {trans_cs, trans_write, trans_btype, trans_asp}, 0);
            chk("rst_gnt_active", gnt_active, 0);
            chk("rst_gnt_id", gnt_id, 0);
            chk("rst_eot", evt_eot, 0);
            m_busy = 0; m_issue = 0; m_rr = 0; m_gnt = '0; m_eot = '0;
            q_addr.delete(); q_len.delete();
        end else begin
            pick = -1;
            if (!m_busy)
                for (int i = 0; i < NB; i++)
                    if (pick < 0 && ch_valid[(m_rr + i) % NB]) pick = (m_rr + i) % NB;
            exp_ready = '0;
            if (pick >= 0) exp_ready[pick] = 1'b1;

            chk("ready", ch_ready, exp_ready);
            chk("trans_valid", trans_valid, m_busy && m_issue);
            if (m_busy && m_issue) begin
                chk("trans_addr", trans_addr, q_addr[0]);
                chk("trans_burst", trans_burst, q_len[0]);
                chk("trans_cs", trans_cs, m_cs);
                chk("trans_write", trans_write, m_wr);
                chk("trans_btype", trans_btype, m_bt);
                chk("trans_asp", trans_asp, m_as);
            end
            chk("gnt_active", gnt_active, m_busy);
            chk("gnt_id", gnt_id, m_gnt);
            chk("eot", evt_eot, m_eot);

            logged = 0;
            for (int i = 0; i < NB; i++)
                if (!logged && ch_ready[i]) begin g_log.push_back(i); logged = 1; end
            if (trans_valid) valid_cycles++;
            if (trans_valid && trans_ready) begin
                c_addr.push_back(trans_addr);
                c_len.push_back(int'(trans_burst));
            end

            m_eot_n = '0;
            if (m_busy && m_issue) begin
                if (trans_ready) m_issue = 0;
            end else if (m_busy && trans_done) begin
                void'(q_addr.pop_front());
                void'(q_len.pop_front());
                if (q_len.size() == 0) begin m_busy = 0; m_eot_n[m_owner] = 1'b1; end
                else m_issue = 1;
            end
            if (pick >= 0) begin
                m_rr  = (pick + 1) % NB;
                m_gnt = IDW'(pick);
                if (ch_burst[pick] == 0) begin
                    m_eot_n[pick] = 1'b1;
                end else begin
                    m_busy = 1; m_issue = 1; m_owner = pick;
                    m_cs = ch_cs[pick]; m_wr = ch_wr[pick]; m_bt = ch_btype[pick]; m_as = ch_asp[pick];
                    rem = int'(ch_burst[pick]);
                    a = ch_addr[pick];
                    while (rem > 0) begin
                        len = (SPLIT && ch_btype[pick] && !ch_asp[pick] && rem > MAXB) ? MAXB : rem;
                        q_addr.push_back(a);
                        q_len.push_back(len);
                        a = a + 32'(len);
                        rem = rem - len;
                    end
                end
            end
            m_eot = m_eot_n;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic set_ch(input int c, input logic [31:0] a, input int len, input bit lin, input bit asp, input bit wr);
        ch_addr[c]  = a;
        ch_burst[c] = TS'(len);
        ch_btype[c] = lin;
        ch_asp[c]   = asp;
        ch_wr[c]    = wr;
        ch_cs[c]    = (c % 2 == 0) ? 2'b01 : 2'b10;
    endtask

    task automatic grant_wait(input int c, input string name);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 400) begin
            @(negedge clk); n++;
            if (ch_ready[c]) seen = 1;
        end
        chk(name, seen, 1);
        @(posedge clk); #1;
        ch_valid[c] = 1'b0;
    endtask

    task automatic request(input int c, input logic [31:0] a, input int len, input bit lin, input bit asp, input bit wr, input string name);
        set_ch(c, a, len, lin, asp, wr);
        ch_valid[c] = 1'b1;
        grant_wait(c, name);
    endtask

    task automatic wait_eot(input int c, input string name);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 6000) begin
            @(negedge clk); n++;
            if (evt_eot[c]) seen = 1;
        end
        chk(name, seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_chunk(input string name, input int idx, input logic [31:0] ea, input int el);
        chk({name, "_addr"}, c_addr[idx], ea);
        chk({name, "_len"}, c_len[idx], el);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gb, cb, vb, n;
        rst_n = 1'b0;
        ch_valid = '0; ch_addr = '0; ch_cs = '0; ch_wr = '0; ch_burst = '0; ch_btype = '0; ch_asp = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single linear request on channel 2
        gb = g_log.size(); cb = c_addr.size();
        request(2, 32'h100, 64, 1, 0, 1, "t1_grant_seen");
        wait_eot(2, "t1_eot");
        chk("t1_grant", g_log[gb], 2);
        chk("t1_nchunks", c_addr.size() - cb, 1);
        chk_chunk("t1_chunk", cb, 32'h100, 64);
        $display("txn single ch2 addr=0x100 burst=64 chunks=%0d", c_addr.size() - cb);

        // Done pulse while idle must be ignored
        stray_req++;
        repeat (4) @(posedge clk);
        #1;

        // Round robin from pointer 0
        do_reset();
        gb = g_log.size();
        set_ch(0, 32'h0, 4, 1, 0, 0);
        set_ch(3, 32'h300, 4, 1, 0, 1);
        set_ch(5, 32'h500, 4, 1, 0, 0);
        ch_valid[0] = 1'b1; ch_valid[3] = 1'b1; ch_valid[5] = 1'b1;
        n = 0;
        while (g_log.size() < gb + 4 && n < 400) begin @(posedge clk); #1; n++; end
        ch_valid = '0;
        chk("rr_four_grants", g_log.size() >= gb + 4, 1);
        wait_eot(0, "rr_eot");
        chk("rr_g0", g_log[gb], 0);
        chk("rr_g1", g_log[gb + 1], 3);
        chk("rr_g2", g_log[gb + 2], 5);
        chk("rr_g3", g_log[gb + 3], 0);
        $display("txn round-robin order %0d %0d %0d %0d", g_log[gb], g_log[gb + 1], g_log[gb + 2], g_log[gb + 3]);

        // Long linear burst
        cb = c_addr.size();
        request(2, 32'h1000, 2500, 1, 0, 0, "split_grant_seen");
        wait_eot(2, "split_eot");
`ifdef HYPER_BURST_SPLIT_EN
        chk("split_nchunks", c_addr.size() - cb, 3);
        chk_chunk("split_c0", cb, 32'h1000, 1024);
        chk_chunk("split_c1", cb + 1, 32'h1400, 1024);
        chk_chunk("split_c2", cb + 2, 32'h1800, 452);
`else
        chk("split_nchunks", c_addr.size() - cb, 1);
        chk_chunk("split_c0", cb, 32'h1000, 2500);
`endif
        $display("txn linear addr=0x1000 burst=2500 chunks=%0d", c_addr.size() - cb);

        // Wrapped burst is never split
        cb = c_addr.size();
        request(6, 32'h2000, 2048, 0, 0, 1, "wrap_grant_seen");
        wait_eot(6, "wrap_eot");
        chk("wrap_nchunks", c_addr.size() - cb, 1);
        chk_chunk("wrap_c0", cb, 32'h2000, 2048);
        $display("txn wrapped addr=0x2000 burst=2048 chunks=%0d", c_addr.size() - cb);

        // Register-space linear burst is never split
        cb = c_addr.size();
        request(3, 32'h40, 2500, 1, 1, 0, "reg_grant_seen");
        wait_eot(3, "reg_eot");
        chk("reg_nchunks", c_addr.size() - cb, 1);
        chk_chunk("reg_c0", cb, 32'h40, 2500);
        $display("txn regspace addr=0x40 burst=2500 chunks=%0d", c_addr.size() - cb);

        // Backpressure, with a stray done while the request is pending
        cb = c_addr.size(); vb = valid_cycles;
        rdy_delay = 10;
        request(1, 32'h3000, 32, 1, 0, 1, "bp_grant_seen");
        stray_req++;
        wait_eot(1, "bp_eot");
        rdy_delay = 0;
        chk("bp_valid_held", valid_cycles - vb >= 11, 1);
        chk("bp_nchunks", c_addr.size() - cb, 1);
        chk_chunk("bp_c0", cb, 32'h3000, 32);
        $display("txn backpressure ch1 valid_cycles=%0d", valid_cycles - vb);

        // Zero-length request
        cb = c_addr.size(); vb = valid_cycles;
        request(7, 32'h500, 0, 1, 0, 0, "zero_grant_seen");
        wait_eot(7, "zero_eot");
        chk("zero_nchunks", c_addr.size() - cb, 0);
        chk("zero_no_valid", valid_cycles - vb, 0);
        $display("txn zero-length ch7 chunks=%0d", c_addr.size() - cb);

        // Address wrap across 2^32
        cb = c_addr.size();
        request(5, 32'hFFFF_FC00, 2048, 1, 0, 0, "awrap_grant_seen");
        wait_eot(5, "awrap_eot");
`ifdef HYPER_BURST_SPLIT_EN
        chk("awrap_nchunks", c_addr.size() - cb, 2);
        chk_chunk("awrap_c0", cb, 32'hFFFF_FC00, 1024);
        chk_chunk("awrap_c1", cb + 1, 32'h0000_0000, 1024);
`else
        chk("awrap_nchunks", c_addr.size() - cb, 1);
        chk_chunk("awrap_c0", cb, 32'hFFFF_FC00, 2048);
`endif
        $display("txn addr-wrap addr=0xFFFFFC00 burst=2048 chunks=%0d", c_addr.size() - cb);

        // Reset while waiting for done
        done_delay = 20;
        request(4, 32'h4000, 64, 1, 0, 0, "rst_grant_seen");
        n = 0;
        while (phy_phase != 1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("rst_reached_wait", phy_phase, 1);
        repeat (3) @(posedge clk);
        #1;
        done_delay = 1;
        set_ch(0, 32'h10, 8, 1, 0, 0);
        set_ch(6, 32'h60, 8, 1, 0, 1);
        ch_valid[0] = 1'b1; ch_valid[6] = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        gb = g_log.size();
        grant_wait(0, "rst_ch0_seen");
        grant_wait(6, "rst_ch6_seen");
        wait_eot(6, "rst_eot6");
        chk("rst_first_grant", g_log[gb], 0);
        chk("rst_second_grant", g_log[gb + 1], 6);
        $display("txn reset-recovery grants %0d %0d", g_log[gb], g_log[gb + 1]);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
